// File: rtl/cpu_phase_sequencer_if.sv
// cpu_phase_sequencer_if: control inputs and phase/commit outputs of the instruction-phase sequencer
interface cpu_phase_sequencer_if #(
    parameter int NUM_PHASES = 4,
    parameter int LEN_W      = 4,
    parameter int CNT_W      = 32,
    parameter int PH_W       = 2
);
    logic                  run;
    logic                  step_req;
    logic                  halt_req;
    logic [LEN_W-1:0]      phase_len;
    logic                  busy;
    logic                  halted;
    logic [PH_W-1:0]       phase_idx;
    logic [NUM_PHASES-1:0] phase_onehot;
    logic [NUM_PHASES-1:0] phase_strobe;
    logic                  instr_done;
    logic [CNT_W-1:0]      instr_count;
    modport master (
        output run, step_req, halt_req, phase_len,
        input  busy, halted, phase_idx, phase_onehot, phase_strobe, instr_done, instr_count
    );
    modport slave (
        input  run, step_req, halt_req, phase_len,
        output busy, halted, phase_idx, phase_onehot, phase_strobe, instr_done, instr_count
    );
endinterface

// File: rtl/cpu_phase_sequencer.sv
// cpu_phase_sequencer: single-clock phase enables and instruction retirement for the multicycle CPU
module cpu_phase_sequencer #(
    parameter int NUM_PHASES = 4,
    parameter int LEN_W      = 4,
    parameter int CNT_W      = 32,
    parameter int PH_W       = 2
) (
    input logic clock,
    input logic reset,
    cpu_phase_sequencer_if.slave bus
);
    typedef enum logic {IDLE, ACTIVE} state_t;
    state_t                state_q, state_d;
    logic [LEN_W-1:0]      cnt_q, cnt_d, len_q, len_d, len_in;
    logic [PH_W-1:0]       ph_q, ph_d;
    logic                  step_q, step_d, halt_q, halt_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  busy, last_cyc, last_ph, stop;
    logic [NUM_PHASES-1:0] onehot;
    always_comb begin
        len_in   = (bus.phase_len == '0) ? LEN_W'(1) : bus.phase_len;
        busy     = state_q == ACTIVE;
        last_cyc = busy && (cnt_q == len_q - LEN_W'(1));
        last_ph  = ph_q == PH_W'(NUM_PHASES - 1);
        stop     = step_q || halt_q || bus.halt_req || !bus.run;
        onehot   = busy ? (NUM_PHASES'(1) << ph_q) : '0;
        state_d  = state_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        ph_d     = ph_q;
        step_d   = step_q;
        halt_d   = halt_q;
        count_d  = count_q;
        if (!busy) begin
            halt_d = 1'b0;
            if (bus.run || bus.step_req) begin
                state_d = ACTIVE;
                step_d  = !bus.run;
                len_d   = len_in;
                ph_d    = '0;
                cnt_d   = '0;
            end
        end else if (!last_cyc) begin
            cnt_d  = cnt_q + LEN_W'(1);
            halt_d = halt_q | bus.halt_req;
        end else if (!last_ph) begin
            cnt_d  = '0;
            ph_d   = ph_q + PH_W'(1);
            halt_d = halt_q | bus.halt_req;
        end else begin
            // instruction boundary: retire, then either idle or relatch length with no bubble
            cnt_d   = '0;
            ph_d    = '0;
            count_d = count_q + CNT_W'(1);
            halt_d  = 1'b0;
            step_d  = 1'b0;
            state_d = stop ? IDLE : ACTIVE;
            len_d   = stop ? len_q : len_in;
        end
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            len_q   <= LEN_W'(1);
            ph_q    <= '0;
            step_q  <= 1'b0;
            halt_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            ph_q    <= ph_d;
            step_q  <= step_d;
            halt_q  <= halt_d;
            count_q <= count_d;
        end
    end
    assign bus.busy         = busy;
    assign bus.halted       = !busy;
    assign bus.phase_idx    = ph_q;
    assign bus.phase_onehot = onehot;
    assign bus.phase_strobe = last_cyc ? onehot : '0;
    assign bus.instr_done   = last_cyc && last_ph;
    assign bus.instr_count  = count_q;
endmodule

// File: tb/tb_cpu_phase_sequencer.sv
// tb_cpu_phase_sequencer: directed checks of phase walking, step, halt, length latching and counter wrap
module tb_cpu_phase_sequencer;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int failures = 0;
    always #5 clock = ~clock;
    cpu_phase_sequencer_if a ();
    cpu_phase_sequencer_if #(.CNT_W(4)) b ();
    cpu_phase_sequencer dut_a (.clock(clock), .reset(reset), .bus(a.slave));
    cpu_phase_sequencer #(.CNT_W(4)) dut_b (.clock(clock), .reset(reset), .bus(b.slave));
    task automatic tick();
        @(posedge clock);
        #1;
    endtask
    task automatic idle_inputs();
        a.run = 0; a.step_req = 0; a.halt_req = 0; a.phase_len = 4'd1;
        b.run = 0; b.step_req = 0; b.halt_req = 0; b.phase_len = 4'd1;
    endtask
    task automatic do_reset();
        idle_inputs();
        reset = 1;
        repeat (3) tick();
        reset = 0;
    endtask
    function automatic logic [12:0] status();
        return {a.busy, a.halted, a.phase_idx, a.phase_onehot, a.phase_strobe, a.instr_done};
    endfunction
    function automatic logic [12:0] active_exp(input int ph, input logic strobe, input logic done);
        logic [3:0] on;
        on = 4'(1 << ph);
        return {1'b1, 1'b0, 2'(ph), on, strobe ? on : 4'b0, done};
    endfunction
    task automatic test_reset();
        do_reset();
        a.run = 1;
        repeat (6) tick();
        #2 reset = 1;
        #1;
        checks++;
        if (a.busy !== 1'b0 || a.instr_count !== 32'd0) begin
            failures++;
            $display("FAIL async_reset: busy=%0b count=%0d want busy=0 count=0", a.busy, a.instr_count);
        end
        repeat (3) tick();
        a.run = 0;
        reset = 0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (status() !== 13'b0_1_00_0000_0000_0 || a.instr_count !== 32'd0) begin
                failures++;
                $display("FAIL reset_idle[%0d]: status=%b count=%0d want 0100000000000 count=0", i, status(), a.instr_count);
            end
            tick();
        end
    endtask
    task automatic test_free_run(input int plen, input int eff, input int n);
        logic [12:0] exp;
        do_reset();
        a.phase_len = 4'(plen);
        a.run = 1;
        for (int i = 0; i < n * 4 * eff; i++) begin
            tick();
            exp = active_exp((i / eff) % 4, (i % eff) == eff - 1, (i % (4 * eff)) == 4 * eff - 1);
            checks++;
            if (status() !== exp) begin
                failures++;
                $display("FAIL free_run_len%0d[%0d]: status=%b want %b", plen, i, status(), exp);
            end
        end
        a.run = 0;
        tick();
        checks++;
        if (a.halted !== 1'b1 || a.instr_count !== 32'(n)) begin
            failures++;
            $display("FAIL free_run_len%0d_end: halted=%0b count=%0d want halted=1 count=%0d", plen, a.halted, a.instr_count, n);
        end
    endtask
    task automatic test_step();
        logic [12:0] exp;
        do_reset();
        a.phase_len = 4'd2;
        a.step_req = 1;
        tick();
        a.step_req = 0;
        for (int i = 0; i < 8; i++) begin
            exp = active_exp(i / 2, (i % 2) == 1, i == 7);
            checks++;
            if (status() !== exp) begin
                failures++;
                $display("FAIL step[%0d]: status=%b want %b", i, status(), exp);
            end
            a.step_req = (i == 3);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (status() !== 13'b0_1_00_0000_0000_0 || a.instr_count !== 32'd1) begin
                failures++;
                $display("FAIL step_idle[%0d]: status=%b count=%0d want 0100000000000 count=1", i, status(), a.instr_count);
            end
            tick();
        end
    endtask
    task automatic test_halt();
        logic [12:0] exp;
        do_reset();
        a.run = 1;
        for (int i = 0; i < 12; i++) begin
            tick();
            exp = active_exp(i % 4, 1'b1, (i % 4) == 3);
            checks++;
            if (status() !== exp) begin
                failures++;
                $display("FAIL halt_run[%0d]: status=%b want %b", i, status(), exp);
            end
            a.halt_req = (i == 9);
        end
        tick();
        checks++;
        if (a.halted !== 1'b1 || a.phase_onehot !== 4'b0 || a.instr_count !== 32'd3) begin
            failures++;
            $display("FAIL halt_stop: halted=%0b onehot=%b count=%0d want halted=1 onehot=0000 count=3", a.halted, a.phase_onehot, a.instr_count);
        end
        do_reset();
        a.run = 1;
        a.halt_req = 1;
        for (int i = 0; i < 8; i++) begin
            tick();
            a.halt_req = 0;
            exp = active_exp(i % 4, 1'b1, (i % 4) == 3);
            checks++;
            if (status() !== exp) begin
                failures++;
                $display("FAIL halt_start_ignored[%0d]: status=%b want %b", i, status(), exp);
            end
        end
        a.halt_req = 1;
        tick();
        a.halt_req = 0;
        checks++;
        if (a.halted !== 1'b1 || a.instr_count !== 32'd2) begin
            failures++;
            $display("FAIL halt_on_boundary: halted=%0b count=%0d want halted=1 count=2", a.halted, a.instr_count);
        end
        a.run = 0;
        tick();
    endtask
    task automatic test_len_change();
        logic [12:0] exp;
        do_reset();
        a.run = 1;
        for (int i = 0; i < 12; i++) begin
            tick();
            exp = (i < 4) ? active_exp(i, 1'b1, i == 3)
                          : active_exp((i - 4) / 2, ((i - 4) % 2) == 1, i == 11);
            checks++;
            if (status() !== exp) begin
                failures++;
                $display("FAIL len_change[%0d]: status=%b want %b", i, status(), exp);
            end
            if (i == 1) a.phase_len = 4'd2;
        end
        a.run = 0;
        tick();
        checks++;
        if (a.halted !== 1'b1 || a.instr_count !== 32'd2) begin
            failures++;
            $display("FAIL len_change_end: halted=%0b count=%0d want halted=1 count=2", a.halted, a.instr_count);
        end
    endtask
    task automatic test_wrap();
        do_reset();
        b.run = 1;
        for (int i = 0; i <= 68; i++) begin
            tick();
            if (i == 60 || i == 64 || i == 68) begin
                checks++;
                if (b.instr_count !== 4'((i / 4) % 16)) begin
                    failures++;
                    $display("FAIL wrap[%0d]: count=%0d want %0d", i, b.instr_count, (i / 4) % 16);
                end
            end
        end
        b.run = 0;
        repeat (4) tick();
    endtask
    initial begin
        test_reset();
        test_free_run(1, 1, 5);
        test_free_run(3, 3, 2);
        test_free_run(0, 1, 3);
        test_step();
        test_halt();
        test_len_change();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
